// File: rtl/apb_ctrl_pkg.sv
// Shared types and defaults for the multi-requester APB master.
package apb_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  localparam int unsigned DEF_NUM_REQ        = 2;
  localparam int unsigned DEF_ADDR_WIDTH     = 32;
  localparam int unsigned DEF_DATA_WIDTH     = 32;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

  function automatic int unsigned tmo_cnt_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a rotating priority pointer.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         pclk,
  input  logic         presetn,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] grant_idx;
  logic [PW-1:0] cand;
  logic          found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = PW'((32'(ptr) + k) % N);
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        found       = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == PW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/apb_arb_master.sv
// APB master that arbitrates NUM_REQ command sources round-robin and runs one
// SETUP/ACCESS transfer at a time, returning data/error with a PREADY timeout.
module apb_arb_master
  import apb_ctrl_pkg::*;
#(
  parameter  int unsigned NUM_REQ        = DEF_NUM_REQ,
  parameter  int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter  int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter  int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int unsigned STRB_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                           pclk,
  input  logic                           presetn,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  input  logic [NUM_REQ*STRB_WIDTH-1:0]  req_strb,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           rsp_err,
  output logic                           psel,
  output logic                           penable,
  output logic                           pwrite,
  output logic [ADDR_WIDTH-1:0]          paddr,
  output logic [DATA_WIDTH-1:0]          pwdata,
  output logic [STRB_WIDTH-1:0]          pstrb,
  input  logic                           pready,
  input  logic                           pslverr,
  input  logic [DATA_WIDTH-1:0]          prdata
);

  localparam int unsigned  CNT_W    = tmo_cnt_width(TIMEOUT_CYCLES);
  localparam bit           TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = TMO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t             state;
  logic [CNT_W-1:0]   wait_cnt;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] owner;
  logic               accept;
  logic               timed_out;

  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [STRB_WIDTH-1:0] sel_strb;

  assign accept    = (state == IDLE) && (req_ready == '0) && (|req_valid);
  assign timed_out = TMO_EN && (wait_cnt == TMO_LAST);

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .pclk    (pclk),
    .presetn (presetn),
    .req     (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_strb  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_strb  = req_strb[i*STRB_WIDTH +: STRB_WIDTH];
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      owner     <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pstrb     <= '0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (req_ready != '0) begin
            state    <= SETUP;
            psel     <= 1'b1;
            wait_cnt <= '0;
          end else if (accept) begin
            // Command goes straight into the bus registers; psel is still low.
            req_ready <= grant;
            owner     <= grant;
            pwrite    <= sel_write;
            paddr     <= sel_addr;
            pwdata    <= sel_wdata;
            pstrb     <= sel_write ? sel_strb : '0;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (pready || timed_out) begin
            rsp_rdata <= (pready && !pwrite) ? prdata : '0;
            rsp_err   <= pready ? pslverr : 1'b1;
            rsp_valid <= owner;
            psel      <= 1'b0;
            penable   <= 1'b0;
            state     <= RESP;
          end else if (TMO_EN) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_arb_master.sv
// Self-checking bench for apb_arb_master: vector table, scoreboarded responses,
// plus contention and mid-transfer reset sequences.
module tb_apb_arb_master;

  localparam int unsigned NR  = 2;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned SW  = DW / 8;
  localparam int unsigned TMO = 16;

  logic              pclk = 1'b0;
  logic              presetn;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     req_write;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR*SW-1:0]  req_strb;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic              psel, penable, pwrite;
  logic [AW-1:0]     paddr;
  logic [DW-1:0]     pwdata;
  logic [SW-1:0]     pstrb;
  logic              pready, pslverr;
  logic [DW-1:0]     prdata;

  int unsigned slv_wait;
  logic        slv_hang;
  logic        slv_err;
  logic [DW-1:0] slv_rdata;
  int unsigned acc_cnt = 0;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic        got_rsp  = 1'b0;

  typedef struct {
    logic [NR-1:0] who;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int unsigned   id;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    int unsigned   waits;
    logic          hang;
    logic          slverr;
    logic [DW-1:0] slv_rdata;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    int unsigned   exp_lat;
  } vec_t;
  vec_t vec [7];

  apb_arb_master #(
    .NUM_REQ        (NR),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_strb  (req_strb),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pstrb     (pstrb),
    .pready    (pready),
    .pslverr   (pslverr),
    .prdata    (prdata)
  );

  always #5 pclk = ~pclk;

  // Completer model: answers after slv_wait unready ACCESS cycles unless hung.
  assign pready  = psel && penable && (acc_cnt >= slv_wait) && !slv_hang;
  assign pslverr = slv_err;
  assign prdata  = slv_rdata;

  always @(posedge pclk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge pclk);
    #1;
    got_rsp = 1'b0;
    if (rsp_valid !== '0) begin
      got_rsp = 1'b1;
      if (sb.size() == 0) begin
        chk("unexpected_rsp", rsp_valid, '0);
      end else begin
        e = sb.pop_front();
        chk("rsp_valid", rsp_valid, e.who);
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err",   rsp_err,   e.err);
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic        done;
    int unsigned lat;
    slv_wait  = v.waits;
    slv_hang  = v.hang;
    slv_err   = v.slverr;
    slv_rdata = v.slv_rdata;
    req_valid[v.id]              = 1'b1;
    req_write[v.id]              = v.wr;
    req_addr[v.id*AW +: AW]      = v.addr;
    req_wdata[v.id*DW +: DW]     = v.wdata;
    req_strb[v.id*SW +: SW]      = v.strb;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      tick();
      if (req_ready !== '0) done = 1'b1;
    end
    chk("req_ready", req_ready, NR'(1) << v.id);
    req_valid[v.id] = 1'b0;
    if (!done) return;
    sb.push_back('{NR'(1) << v.id, v.exp_rdata, v.exp_err});
    done = 1'b0;
    lat  = 0;
    for (int c = 1; c <= 40 && !done; c++) begin
      tick();
      if (c == 1) chk("setup_phase", {psel, penable, paddr}, {2'b10, v.addr});
      if (psel && penable)
        chk("access_stable", {pwrite, paddr, pwdata, pstrb},
            {v.wr, v.addr, v.wdata, (v.wr ? v.strb : 4'h0)});
      if (got_rsp) begin
        done = 1'b1;
        lat  = c;
        chk("rsp_bus_idle", {psel, penable}, 2'b00);
      end
    end
    chk("rsp_latency", lat, v.exp_lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NR-1:0] eg [4];
    int unsigned   gcnt [NR];
    int            k, last_acc, idx, rsp_cnt;
    logic          seen;

    //           id wr addr          wdata         strb  wt hang serr slv_rdata      exp_rdata      eerr lat
    vec[0] = '{0, 1'b0, 32'h0000_0004, 32'h0,         4'hF, 0,  1'b0, 1'b0, 32'hCAFE_0004, 32'hCAFE_0004, 1'b0, 3};
    vec[1] = '{1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3,  1'b0, 1'b0, 32'h5555_5555, 32'h0,         1'b0, 6};
    vec[2] = '{0, 1'b0, 32'h0000_0003, 32'h0,         4'h0, 0,  1'b0, 1'b1, 32'h0BAD_0003, 32'h0BAD_0003, 1'b1, 3};
    vec[3] = '{1, 1'b0, 32'h0000_0020, 32'h0,         4'h0, 0,  1'b1, 1'b0, 32'h1234_5678, 32'h0,         1'b1, 18};
    vec[4] = '{0, 1'b1, 32'h0000_0008, 32'h0102_0304, 4'h3, 1,  1'b0, 1'b1, 32'h7777_7777, 32'h0,         1'b1, 4};
    vec[5] = '{1, 1'b0, 32'h0000_0024, 32'h0,         4'h0, 15, 1'b0, 1'b0, 32'hA5A5_0024, 32'hA5A5_0024, 1'b0, 18};
    vec[6] = '{1, 1'b0, 32'h0000_0040, 32'h0,         4'h0, 0,  1'b0, 1'b0, 32'h600D_0040, 32'h600D_0040, 1'b0, 3};
    eg[0] = 2'b01; eg[1] = 2'b10; eg[2] = 2'b01; eg[3] = 2'b10;

    presetn   = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_strb  = '0;
    slv_wait  = 0;
    slv_hang  = 1'b0;
    slv_err   = 1'b0;
    slv_rdata = '0;
    repeat (3) tick();
    chk("reset_outputs",
        {req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata, pstrb}, '0);
    presetn = 1'b1;
    tick();

    // Contention: both requesters hold valid for two transfers each.
    req_valid = 2'b11;
    req_addr[0 +: AW]  = 32'h0000_0100;
    req_addr[AW +: AW] = 32'h0000_0200;
    gcnt[0] = 0; gcnt[1] = 0;
    k = 0; last_acc = 0;
    for (int c = 0; c < 80 && !(k >= 4 && sb.size() == 0); c++) begin
      tick();
      if (req_ready !== '0) begin
        if (k < 4) begin
          chk("rr_grant", req_ready, eg[k]);
          if (k > 0) chk("b2b_period", c - last_acc, 5);
          last_acc  = c;
          slv_rdata = 32'hC0DE_0000 | k;
          sb.push_back('{eg[k], slv_rdata, 1'b0});
          idx = req_ready[1] ? 1 : 0;
          gcnt[idx]++;
          if (gcnt[idx] == 2) req_valid[idx] = 1'b0;
        end
        k++;
      end
    end
    chk("contention_grants", k, 4);
    chk("contention_pending", sb.size(), 0);
    req_valid = '0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vec[i]);
    tick();

    // Reset during ACCESS: bus clears at once and the aborted command never responds.
    slv_hang  = 1'b1;
    slv_err   = 1'b0;
    req_valid[0]       = 1'b1;
    req_write[0]       = 1'b0;
    req_addr[0 +: AW]  = 32'h0000_0030;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (req_ready !== '0) seen = 1'b1;
    end
    chk("abort_accept", req_ready, 2'b01);
    req_valid[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      tick();
      if (psel && penable) seen = 1'b1;
    end
    chk("abort_in_access", {psel, penable}, 2'b11);
    tick();
    presetn = 1'b0;
    #1;
    chk("reset_async_clear",
        {req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata, pstrb}, '0);
    sb.delete();
    repeat (2) tick();
    presetn  = 1'b1;
    slv_hang = 1'b0;
    rsp_cnt  = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (got_rsp) rsp_cnt++;
    end
    chk("no_rsp_after_abort", rsp_cnt, 0);
    run_vec(vec[6]);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_arb_master.md
# apb_arb_master

Multi-requester APB master controller that sits between on-chip command sources and the APB bus. It accepts read/write commands from NUM_REQ requesters, arbitrates round-robin, and sequences each one through the APB SETUP/ACCESS phases. It returns read data and error status to the winning requester and bounds every transfer with a PREADY timeout. It replaces hand-driven bridge stimulus as the APB requester in integrated designs.

## Interface
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_WIDTH, 32, APB address width
- DATA_WIDTH, 32, APB data width; STRB_WIDTH = DATA_WIDTH/8
- TIMEOUT_CYCLES, 16, max ACCESS-phase cycles waiting for pready; 0 disables the timeout
- Clocking: one clock; reset is asynchronous and active-low
- pclk  in  1  clock
- presetn  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester command valid
- req_ready  out  NUM_REQ  one-hot, one-cycle command-accept pulse
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i at slice i
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data
- req_strb  in  NUM_REQ*STRB_WIDTH  flattened write strobes
- rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse
- rsp_rdata  out  DATA_WIDTH  read data; valid with rsp_valid
- rsp_err  out  1  pslverr or timeout; valid with rsp_valid
- psel, penable, pwrite  out  1  APB control
- paddr  out  ADDR_WIDTH  APB address, passed unmodified; alignment checking belongs to the slave
- pwdata  out  DATA_WIDTH  APB write data
- pstrb  out  STRB_WIDTH  APB strobes; forced to 0 on reads
- pready, pslverr  in  1  APB completer response
- prdata  in  DATA_WIDTH  APB read data

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If any req_valid is high, the arbiter grants one requester.
  - The controller pulses req_ready for that requester and registers write, addr, wdata and strb.
  - Next state is SETUP.
- SETUP:
  - psel=1, penable=0, and the command is driven on the APB bus.
  - Next state is always ACCESS.
- ACCESS:
  - psel=1, penable=1.
  - The APB command signals stay stable until exit.
  - If pready is high, the controller captures prdata (reads only; 0 for writes) and pslverr, then moves to RESP.
  - If pready is low, a wait counter increments.
  - If the counter reaches TIMEOUT_CYCLES, the controller forces the error flag to 1, sets the captured data to 0, and moves to RESP.
- RESP:
  - psel=0, penable=0.
  - rsp_valid pulses for the granted requester, with rsp_rdata and rsp_err.
  - Next state is IDLE.
- Round-robin arbitration:
  - The search starts at the priority pointer.
  - After a grant, the pointer moves to grant+1, modulo NUM_REQ.
  - Ties among requests are resolved only by the pointer.
- Command sampling:
  - req_valid is sampled only in IDLE.
  - A requester must hold its command until req_ready.
  - A requester dropping req_valid before being granted is legal and loses nothing.
- Only one transfer is outstanding at a time; there is no pipelining.

## Timing
- Reset values: all outputs 0, state IDLE, pointer 0, wait counter 0.
- Reset may assert at any point. If it asserts mid-transfer, psel and penable clear immediately and no rsp_valid is issued for the aborted command.
- Cycle numbering for one transfer, with zero-wait pready:
  - Cycle 0: accept (req_ready).
  - Cycle 1: SETUP.
  - Cycle 2: ACCESS, with pready sampled at the end.
  - Cycle 3: rsp_valid.
- Each wait state adds one cycle.
- Back-to-back: the next accept happens in the IDLE cycle after RESP, so the minimum period is 5 cycles per transfer.
- All outputs are registered; none depend combinationally on inputs.
- Timeout:
  - The wait counter resets on SETUP entry.
  - With TIMEOUT_CYCLES=N, the timeout response is issued after N ACCESS cycles without pready.
  - pready arriving on the final counted cycle wins over the timeout.

## Structure
- The package apb_ctrl_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS, RESP);
  - default width constants;
  - the timeout counter width function, $clog2(TIMEOUT_CYCLES+1).
- Sub-module rr_arbiter (parameter N), with:
  - inputs: req[N], advance;
  - output: one-hot grant[N];
  - an internal priority pointer.

## Test plan
- Single read: req 0, addr 0x4, slave returns 0xCAFE_0004 with zero wait. Expected: req_ready at cycle 0, SETUP at cycle 1, ACCESS at cycle 2, rsp_valid[0] at cycle 3, rsp_rdata 0xCAFE_0004, rsp_err 0.
- Write with 3 wait states: req 1, addr 0x10, data 0xDEADBEEF, strb 0xF. Expected: APB signals stable through all ACCESS cycles, rsp_valid[1] at cycle 6, rsp_err 0.
- Contention: both requesters hold valid for 4 transfers. Expected: grants alternate 0, 1, 0, 1 starting from reset, with no starvation.
- Slave error: read of addr 0x3 where the slave asserts pslverr with pready. Expected: rsp_err 1, and paddr equals 0x3 on the bus.
- Timeout: pready is never asserted and TIMEOUT_CYCLES=16. Expected: rsp_valid after 16 ACCESS cycles, rsp_err 1, rsp_rdata 0, then psel and penable return to 0.
- Reset mid-transfer: presetn asserts during ACCESS. Expected: all outputs 0 immediately, no rsp_valid, and a clean transfer succeeds after release.
